// File: rtl/risc16_boot_ctrl.sv
// Boot loader: packs big-endian byte pairs from a valid/ready stream into instruction memory, then holds the risc16f core in reset.
// mem_we fires the cycle after the low-byte handshake; s_ready is high only while waiting for a byte, so s_valid may stall freely.
module risc16_boot_ctrl #(
  parameter logic [15:0] BASE_ADDR = 16'h0000,
  parameter int unsigned RST_HOLD  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] len,
  input  logic [7:0]  s_data,
  input  logic        s_valid,
  output logic        s_ready,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_din,
  output logic        mem_we,
  output logic        core_rst,
  output logic        busy,
  output logic        done
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD_HI,
    LOAD_LO,
    WRITE,
    HOLD,
    RUN
  } state_t;

  // Hold counter counts down to zero, so HOLD lasts exactly RST_HOLD cycles.
  localparam logic [7:0] HOLD_INIT = 8'(RST_HOLD - 1);

  state_t      state_q, state_d;
  logic [15:0] len_q, len_d;
  logic [15:0] count_q, count_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] din_q, din_d;
  logic [7:0]  hold_q, hold_d;
  logic        we_q, we_d;
  logic        ready_q, ready_d;
  logic        core_rst_q, core_rst_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [15:0] count_inc;

  assign count_inc = count_q + 16'd1;

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    count_d = count_q;
    addr_d  = addr_q;
    din_d   = din_q;
    hold_d  = hold_q;

    case (state_q)
      IDLE, RUN: begin
        if (start) begin
          len_d   = len;
          count_d = 16'd0;
          addr_d  = BASE_ADDR;
          if (len != 16'd0) begin
            state_d = LOAD_HI;
          end else begin
            hold_d  = HOLD_INIT;
            state_d = HOLD;
          end
        end
      end
      LOAD_HI: begin
        if (s_valid && ready_q) begin
          din_d[15:8] = s_data;
          state_d     = LOAD_LO;
        end
      end
      LOAD_LO: begin
        if (s_valid && ready_q) begin
          din_d[7:0] = s_data;
          state_d    = WRITE;
        end
      end
      WRITE: begin
        // Address wraps naturally at 16 bits (0xFFFE -> 0x0000).
        addr_d  = addr_q + 16'd2;
        count_d = count_inc;
        if (count_inc == len_q) begin
          hold_d  = HOLD_INIT;
          state_d = HOLD;
        end else begin
          state_d = LOAD_HI;
        end
      end
      HOLD: begin
        if (hold_q == 8'd0) begin
          state_d = RUN;
        end else begin
          hold_d = hold_q - 8'd1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Outputs are decoded from the next state so they register alongside it.
    we_d       = (state_d == WRITE);
    ready_d    = (state_d == LOAD_HI) || (state_d == LOAD_LO);
    core_rst_d = (state_d != RUN);
    busy_d     = (state_d == LOAD_HI) || (state_d == LOAD_LO) ||
                 (state_d == WRITE)   || (state_d == HOLD);
    done_d     = (state_d == RUN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      len_q      <= 16'd0;
      count_q    <= 16'd0;
      addr_q     <= BASE_ADDR;
      din_q      <= 16'd0;
      hold_q     <= 8'd0;
      we_q       <= 1'b0;
      ready_q    <= 1'b0;
      core_rst_q <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      count_q    <= count_d;
      addr_q     <= addr_d;
      din_q      <= din_d;
      hold_q     <= hold_d;
      we_q       <= we_d;
      ready_q    <= ready_d;
      core_rst_q <= core_rst_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign s_ready  = ready_q;
  assign mem_addr = addr_q;
  assign mem_din  = din_q;
  assign mem_we   = we_q;
  assign core_rst = core_rst_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_risc16_boot_ctrl.sv
// Bench for risc16_boot_ctrl: two instances (base 0x0000 and 0xFFFE) share one stimulus stream.
module tb_risc16_boot_ctrl;

  localparam int          RST_HOLD = 4;
  localparam logic [15:0] BASE_B   = 16'hFFFE;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] len;
  logic [7:0]  s_data;
  logic        s_valid;

  logic        s_ready_a, mem_we_a, core_rst_a, busy_a, done_a;
  logic [15:0] mem_addr_a, mem_din_a;
  logic        s_ready_b, mem_we_b, core_rst_b, busy_b, done_b;
  logic [15:0] mem_addr_b, mem_din_b;

  int checks = 0;
  int errors = 0;
  logic [7:0] bytes_q[$];
  bit aborted;

  always #5 clk = ~clk;

  risc16_boot_ctrl #(.BASE_ADDR(16'h0000), .RST_HOLD(RST_HOLD)) dut_a (
    .clk(clk), .rst(rst), .start(start), .len(len),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready_a),
    .mem_addr(mem_addr_a), .mem_din(mem_din_a), .mem_we(mem_we_a),
    .core_rst(core_rst_a), .busy(busy_a), .done(done_a)
  );

  risc16_boot_ctrl #(.BASE_ADDR(BASE_B), .RST_HOLD(RST_HOLD)) dut_b (
    .clk(clk), .rst(rst), .start(start), .len(len),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready_b),
    .mem_addr(mem_addr_b), .mem_din(mem_din_b), .mem_we(mem_we_b),
    .core_rst(core_rst_b), .busy(busy_b), .done(done_b)
  );

  task automatic chk1(input string tag, input logic obs, input logic exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp_v);
    end
  endtask

  task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=0x%04h expected=0x%04h", tag, obs, exp_v);
    end
  endtask

  // Status outputs of both instances against one expected tuple.
  task automatic chk_status(input string tag, input logic e_rst, input logic e_busy,
                            input logic e_done, input logic e_rdy);
    chk1({tag, "_core_rst_a"}, core_rst_a, e_rst);
    chk1({tag, "_core_rst_b"}, core_rst_b, e_rst);
    chk1({tag, "_busy_a"}, busy_a, e_busy);
    chk1({tag, "_busy_b"}, busy_b, e_busy);
    chk1({tag, "_done_a"}, done_a, e_done);
    chk1({tag, "_done_b"}, done_b, e_done);
    chk1({tag, "_s_ready_a"}, s_ready_a, e_rdy);
    chk1({tag, "_s_ready_b"}, s_ready_b, e_rdy);
  endtask

  task automatic fill_random(input int n);
    bytes_q.delete();
    for (int i = 0; i < 2 * n; i++) bytes_q.push_back(8'($urandom));
  endtask

  // Reference model: the loader wants 2n bytes in order; each completed byte pair
  // becomes one write on the next cycle (ready drops for that cycle), then the core
  // sits in reset RST_HOLD more cycles before running. Called at a negedge.
  task automatic do_load(input string tag, input int n, input int vmode, input bit noise,
                         input int abort_at, output bit was_aborted);
    int  sent, widx, last_idx;
    bit  exp_we, exp_ready, hs, ended;
    logic [15:0] exp_data;
    was_aborted = 1'b0;
    ended       = 1'b0;
    start   = 1'b1;
    len     = 16'(n);
    s_valid = 1'b0;
    @(negedge clk);
    start = 1'b0;
    len   = 16'($urandom);
    sent     = 0;
    widx     = 0;
    exp_we   = 1'b0;
    last_idx = (n == 0) ? -1 : 1000000;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      if (abort_at >= 0 && sent == abort_at) begin
        was_aborted = 1'b1;
        break;
      end
      exp_ready = !exp_we && (sent < 2 * n);
      chk1({tag, "_mem_we_a"}, mem_we_a, exp_we);
      chk1({tag, "_mem_we_b"}, mem_we_b, exp_we);
      if (exp_we) begin
        exp_data = {bytes_q[2 * widx], bytes_q[2 * widx + 1]};
        chk16({tag, "_addr_a"}, mem_addr_a, 16'(2 * widx));
        chk16({tag, "_addr_b"}, mem_addr_b, BASE_B + 16'(2 * widx));
        chk16({tag, "_din_a"}, mem_din_a, exp_data);
        chk16({tag, "_din_b"}, mem_din_b, exp_data);
        widx++;
        if (widx == n) last_idx = cyc;
      end
      if (cyc > last_idx && (cyc - last_idx) > RST_HOLD) begin
        chk_status({tag, "_run"}, 1'b0, 1'b0, 1'b1, 1'b0);
        ended = 1'b1;
        break;
      end
      chk_status({tag, "_busy"}, 1'b1, 1'b1, 1'b0, exp_ready);
      case (vmode)
        0:       s_valid = 1'b1;
        1:       s_valid = (cyc % 2 == 0);
        default: s_valid = 1'($urandom_range(0, 1));
      endcase
      s_data = (s_valid && exp_ready) ? bytes_q[sent] : 8'($urandom);
      if (noise) begin
        start = 1'($urandom_range(0, 1));
        len   = 16'($urandom);
      end
      hs     = s_valid && exp_ready;
      exp_we = hs && (sent % 2 == 1);
      if (hs) sent++;
      @(negedge clk);
    end
    start   = 1'b0;
    s_valid = 1'b0;
    chk1({tag, "_completed"}, ended || was_aborted, 1'b1);
  endtask

  initial begin
    rst     = 1'b1;
    start   = 1'b0;
    len     = 16'd0;
    s_valid = 1'b0;
    s_data  = 8'd0;
    @(negedge clk);
    @(negedge clk);
    chk_status("reset", 1'b1, 1'b0, 1'b0, 1'b0);
    chk1("reset_we_a", mem_we_a, 1'b0);
    chk16("reset_addr_a", mem_addr_a, 16'h0000);
    chk16("reset_addr_b", mem_addr_b, BASE_B);
    chk16("reset_din_a", mem_din_a, 16'h0000);

    // Stream offered while idle without start must be ignored.
    rst     = 1'b0;
    s_valid = 1'b1;
    s_data  = 8'h5A;
    repeat (3) @(negedge clk);
    chk_status("idle", 1'b1, 1'b0, 1'b0, 1'b0);
    chk1("idle_we", mem_we_a, 1'b0);
    s_valid = 1'b0;

    bytes_q = '{8'h12, 8'h34, 8'h56, 8'h78};
    do_load("basic", 2, 0, 1'b0, -1, aborted);

    fill_random(1);
    do_load("reload", 1, 2, 1'b0, -1, aborted);

    bytes_q = '{8'hAB, 8'hCD};
    do_load("toggle", 1, 1, 1'b0, -1, aborted);

    bytes_q.delete();
    do_load("len0", 0, 0, 1'b0, -1, aborted);

    fill_random(5);
    do_load("noisy", 5, 2, 1'b1, -1, aborted);

    // Reset after the high byte of the second word.
    fill_random(2);
    do_load("abort", 2, 0, 1'b1, 3, aborted);
    chk1("abort_reached", aborted, 1'b1);
    rst     = 1'b1;
    start   = 1'b0;
    s_valid = 1'b1;
    @(negedge clk);
    chk_status("midrst", 1'b1, 1'b0, 1'b0, 1'b0);
    chk1("midrst_we_a", mem_we_a, 1'b0);
    chk16("midrst_addr_a", mem_addr_a, 16'h0000);
    chk16("midrst_addr_b", mem_addr_b, BASE_B);
    chk16("midrst_din_b", mem_din_b, 16'h0000);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      s_data = 8'($urandom);
      @(negedge clk);
      chk1("postrst_we_a", mem_we_a, 1'b0);
      chk1("postrst_we_b", mem_we_b, 1'b0);
      chk_status("postrst", 1'b1, 1'b0, 1'b0, 1'b0);
    end
    s_valid = 1'b0;

    fill_random(3);
    do_load("recover", 3, 2, 1'b0, -1, aborted);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
